muladd_checker: RTL
===================

MULADD_CHECKER -- requirements
Module: muladd_checker

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning DUT cycles from operand presentation to valid y (legal 1..8).
REQ-002 SHALL have parameter NUM_VECTORS, default 256, meaning vectors driven per run (legal 1..65535).
REQ-003 SHALL have parameter SEED, default 32'hACE1_0001, meaning LFSR load value (zero treated as 32'h1).
REQ-004 SHALL have port clock  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin run when sampled high in IDLE or DONE.
REQ-007 SHALL have port mode  input  1  0 = LFSR operands, 1 = directed operands dir_a/dir_b/dir_c.
REQ-008 SHALL have ports dir_a  input  8, dir_b  input  8, dir_c  input  16, meaning directed signed operands, sampled each DRIVE cycle.
REQ-009 SHALL have ports a  output  8, b  output  8, c  output  16, meaning signed operands to the multiply-add DUT.
REQ-010 SHALL have port en  output  1  DUT pipeline enable.
REQ-011 SHALL have port y  input  16  signed DUT result.
REQ-012 SHALL have ports busy  output  1, done  output  1, pass  output  1, meaning run status.
REQ-013 SHALL have ports err_count  output  16, first_err_idx  output  16, meaning mismatch total and index of first mismatching vector.

Function
REQ-014 SHALL implement FSM IDLE -> DRIVE (start) -> DRAIN (after NUM_VECTORS DRIVE cycles) -> DONE (after LATENCY DRAIN cycles) -> DRIVE (start).
REQ-015 SHALL, on the start edge, reload LFSR with SEED, clear err_count to 0, set first_err_idx to 16'hFFFF, clear vector index to 0.
REQ-016 SHALL, in DRIVE, present one vector per cycle with en=1; LFSR mode: a=lfsr[7:0], b=lfsr[15:8], c=lfsr[31:16], LFSR advancing one Galois step (polynomial 32'h8020_0003) per vector.
REQ-017 SHALL, in DRAIN, hold a=b=c=0 and en=1; in IDLE and DONE, a=b=c=0 and en=0.
REQ-018 SHALL compute expected = signed(a)*signed(b)+signed(c) at full precision, truncated to 16 bits (two's-complement wrap), in the cycle the vector is presented.
REQ-019 SHALL carry expected value, valid bit and vector index through a LATENCY-deep shift register advancing every cycle en=1.
REQ-020 SHALL compare y against the delay-line output when its valid bit is set; y for a vector presented in cycle t is sampled at the end of cycle t+LATENCY.
REQ-021 SHALL on mismatch increment err_count (saturating at 16'hFFFF) and, if first_err_idx is 16'hFFFF, load it with that vector's index.
REQ-022 SHALL assert busy in DRIVE and DRAIN only; done in DONE only; pass = done and err_count==0.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL enter DONE exactly 1+NUM_VECTORS+LATENCY cycles after the start edge; the last compare occurs in the final DRAIN cycle.
REQ-025 SHALL hold err_count and first_err_idx stable in DONE until the next start.

Reset
REQ-026 SHALL, on reset low at a rising edge, enter IDLE, load LFSR with SEED, clear delay-line valid bits, and drive a=b=c=0, en=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=16'hFFFF.
REQ-027 SHALL abort a run when reset is asserted mid-DRIVE or mid-DRAIN; no compare of in-flight vectors occurs afterwards.

Verification
REQ-028 SHALL cover: mode=1, dir_a=127, dir_b=1, dir_c=-150, NUM_VECTORS=16, ideal DUT model LATENCY=2 -> every expected = -23, done 19 cycles after start, pass=1, err_count=0.
REQ-029 SHALL cover: mode=1, dir_a=-128, dir_b=-128, dir_c=32767 -> expected wraps to -16385; ideal model gives pass=1.
REQ-030 SHALL cover: mode=0, NUM_VECTORS=16, DUT model with y bit0 inverted -> err_count=16, first_err_idx=0, pass=0.
REQ-031 SHALL cover: mode=0, DUT model LATENCY=3 against checker LATENCY=2 -> err_count>0, first_err_idx=0, pass=0.
REQ-032 SHALL cover: reset low for one cycle at DRIVE vector 5 -> next cycle IDLE, busy=0, en=0, err_count=0; subsequent start reproduces the identical LFSR sequence from SEED.
REQ-033 SHALL cover: start pulsed during DRIVE -> no restart, done timing unchanged.

Source files
------------

// File: rtl/muladd_checker.sv
// Stimulus generator and result checker for a pipelined signed multiply-add unit.
// Drives LFSR or directed operands, predicts a*b+c, and scores the delayed DUT result.
module muladd_checker #(
  parameter int          LATENCY     = 2,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  dir_a,
  input  logic [7:0]  dir_b,
  input  logic [15:0] dir_c,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [15:0] c,
  output logic        en,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx
);

  localparam logic [31:0] POLY       = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF   = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);
  localparam logic [15:0] NO_ERR     = 16'hFFFF;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] lfsr;
  logic [15:0] vec_idx;
  logic [3:0]  drain_cnt;
  logic        launch;

  // Start is only honoured when no run is in flight.
  assign launch = start && (state == S_IDLE || state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRIVE;
      S_DRIVE: if (vec_idx == LAST_VEC) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_DRIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    a    = '0;
    b    = '0;
    c    = '0;
    en   = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_DRIVE: begin
        en   = 1'b1;
        busy = 1'b1;
        if (mode) begin
          a = dir_a;
          b = dir_b;
          c = dir_c;
        end else begin
          a = lfsr[7:0];
          b = lfsr[15:8];
          c = lfsr[31:16];
        end
      end
      S_DRAIN: begin
        en   = 1'b1;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (err_count == 16'h0);

  // Operand source and run counters.
  always_ff @(posedge clock) begin
    if (!reset || launch) begin
      lfsr      <= SEED_EFF;
      vec_idx   <= '0;
      drain_cnt <= '0;
    end else if (state == S_DRIVE) begin
      lfsr    <= (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'h0);
      vec_idx <= vec_idx + 16'd1;
    end else if (state == S_DRAIN) begin
      drain_cnt <= drain_cnt + 4'd1;
    end
  end

  // Expected result: sign-extend first so the 16-bit product keeps the correct low bits.
  logic signed [15:0] a_s;
  logic signed [15:0] b_s;
  logic signed [15:0] prod;
  logic        [15:0] exp_now;

  assign a_s     = {{8{a[7]}}, a};
  assign b_s     = {{8{b[7]}}, b};
  assign prod    = a_s * b_s;
  assign exp_now = prod + c;

  logic [LATENCY-1:0] dl_vld;
  logic [15:0]        dl_exp [LATENCY];
  logic [15:0]        dl_idx [LATENCY];

  always_ff @(posedge clock) begin
    if (!reset || launch) begin
      dl_vld <= '0;
    end else if (en) begin
      for (int i = LATENCY - 1; i > 0; i--) dl_vld[i] <= dl_vld[i-1];
      dl_vld[0] <= (state == S_DRIVE);
    end
  end

  // NOTE: payload storage is not reset; only the valid bits need a defined value.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        dl_exp[i] <= dl_exp[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
      dl_exp[0] <= exp_now;
      dl_idx[0] <= vec_idx;
    end
  end

  logic mismatch;
  assign mismatch = en && dl_vld[LATENCY-1] && (y != dl_exp[LATENCY-1]);

  always_ff @(posedge clock) begin
    if (!reset || launch) begin
      err_count     <= '0;
      first_err_idx <= NO_ERR;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (first_err_idx == NO_ERR) first_err_idx <= dl_idx[LATENCY-1];
    end
  end

endmodule
